dds_burst_sequencer: RTL and testbench
======================================

// Module: dds_burst_sequencer
// PURPOSE
//  Sequences a burst of NUM pulses for the DDS datapath. Drives the clear/enable inputs of the
//  downstream phase/sample counter so it runs only inside each pulse and restarts from 0 per pulse.
//  Sits between the host/config interface and the counter. Sampled-config start/done handshake.
// PARAMETERS
//  CNT_W  16  width of CFG_WIDTH / CFG_PERIOD and the internal tick timer
//  NUM_W  8   width of CFG_NUM and PULSE_IDX
// PORTS
//  CLK         in   1      clock, all logic on rising edge
//  RESET       in   1      reset, asynchronous, active-high
//  START       in   1      request burst; accepted only in IDLE
//  ABORT       in   1      cancel burst; priority over START
//  CFG_WIDTH   in   CNT_W  pulse high time, cycles; sampled when START is accepted
//  CFG_PERIOD  in   CNT_W  pulse repetition period, cycles; sampled when START is accepted
//  CFG_NUM     in   NUM_W  pulses per burst; sampled when START is accepted
//  BUSY        out  1      high in LOAD/HIGH/LOW
//  PULSE       out  1      high in HIGH
//  CNT_EN      out  1      counter enable; equals PULSE
//  CNT_CLR     out  1      one-cycle counter clear, cycle before every HIGH phase
//  PULSE_IDX   out  NUM_W  index of current/next pulse, 0..CFG_NUM-1
//  DONE        out  1      one-cycle strobe, burst completed normally
//  CFG_ERR     out  1      one-cycle strobe, START rejected for bad config
// BEHAVIOUR
//  - All outputs registered. RESET -> state IDLE, every output 0, config regs 0, timer 0.
//  - States: IDLE, LOAD, HIGH, LOW, FIN.
//  - IDLE, START=1, ABORT=0: config valid if WIDTH!=0 && PERIOD>WIDTH && NUM!=0 (unsigned
//    compares). Valid -> latch config, LOAD. Invalid -> CFG_ERR=1 for 1 cycle, stay IDLE.
//  - LOAD (exactly 1 cycle): BUSY=1, CNT_CLR=1, PULSE_IDX=0 -> HIGH.
//  - HIGH: PULSE=CNT_EN=1 for exactly WIDTH cycles -> LOW.
//  - LOW: PERIOD-WIDTH cycles (CNT_W-bit subtract; no underflow given validity check).
//    Last LOW cycle: if PULSE_IDX==NUM-1 -> FIN; else CNT_CLR=1, PULSE_IDX+1, -> HIGH.
//  - Rising edges of PULSE are exactly PERIOD cycles apart; no gap cycle inserted between pulses.
//  - FIN (1 cycle): DONE=1, BUSY=0 -> IDLE. START in FIN is ignored.
//  - Latency: START sampled in cycle 0 -> LOAD cycle 1, first HIGH cycle 2, FIN cycle 2+NUM*PERIOD.
//  - START while BUSY: ignored. Config inputs changing mid-burst: no effect, latched copy used.
//  - ABORT in any state: next cycle IDLE, all outputs 0, no DONE. ABORT+START same cycle in IDLE:
//    stay IDLE, no CFG_ERR.
//  - RESET mid-burst: outputs drop asynchronously to reset values. Next START after release is a
//    fresh burst.
//  - Max values: WIDTH up to 2^CNT_W-2, PERIOD up to 2^CNT_W-1, NUM up to 2^NUM_W-1.
//    Timer and PULSE_IDX never wrap inside a burst.
// STRUCTURE
//  - Package dds_ctrl_pkg: state encoding (IDLE/LOAD/HIGH/LOW/FIN) and default CNT_W/NUM_W.
//    Shared with other DDS control blocks.
//  - Sub-module dds_tick_timer: loadable down-counter (LOAD, VALUE[CNT_W], EXPIRE flag on last
//    count). Loaded with WIDTH on entry to HIGH, PERIOD-WIDTH on entry to LOW.
//  - Top: FSM, config latch, pulse index counter, output registers.
// TESTING
//  - W=3,P=5,N=2, START cycle 0 -> CNT_CLR in cycles 1,6; PULSE in 2-4,7-9; DONE cycle 12;
//    BUSY 1-11.
//  - W=1,P=2,N=1 (minimum) -> CNT_CLR cycle 1, PULSE cycle 2, LOW cycle 3, DONE cycle 4.
//  - Bad configs W=0 / P=W=4 / N=0 -> CFG_ERR one cycle each, BUSY stays 0, no CNT_CLR.
//  - W=3,P=5,N=4, ABORT in cycle 8 -> all outputs 0 from cycle 9, DONE never asserted;
//    new START later behaves as test 1.
//  - START re-pulsed during HIGH/LOW with different CFG_* -> burst timing unchanged;
//    START+ABORT in IDLE -> nothing.
//  - RESET asserted mid-HIGH between clock edges -> PULSE/BUSY/CNT_EN 0 immediately;
//    held 2 cycles, released, START -> normal burst.

Source files
------------

// File: rtl/dds_ctrl_pkg.sv
// Shared DDS control definitions: burst sequencer state encoding and default widths.
package dds_ctrl_pkg;

  localparam int unsigned DDS_CNT_W = 16;
  localparam int unsigned DDS_NUM_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HIGH = 3'd2,
    ST_LOW  = 3'd3,
    ST_FIN  = 3'd4
  } dds_state_t;

endpackage

// File: rtl/dds_tick_timer.sv
// Loadable down-counter; expire is a registered flag that is high while count == 1,
// i.e. during the last cycle of the loaded interval.
module dds_tick_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic [CNT_W-1:0] count,
  output logic             expire
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      expire <= 1'b0;
    end else if (load) begin
      count  <= value;
      expire <= (value == CNT_W'(1));
    end else begin
      if (count != '0) count <= count - CNT_W'(1);
      expire <= (count == CNT_W'(2));
    end
  end

endmodule

// File: rtl/dds_burst_sequencer.sv
// Burst sequencer: emits CFG_NUM pulses of CFG_WIDTH cycles every CFG_PERIOD cycles and
// drives clear/enable of the downstream phase/sample counter.
module dds_burst_sequencer
  import dds_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = DDS_CNT_W,
  parameter int unsigned NUM_W = DDS_NUM_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic             ABORT,
  input  logic [CNT_W-1:0] CFG_WIDTH,
  input  logic [CNT_W-1:0] CFG_PERIOD,
  input  logic [NUM_W-1:0] CFG_NUM,
  output logic             BUSY,
  output logic             PULSE,
  output logic             CNT_EN,
  output logic             CNT_CLR,
  output logic [NUM_W-1:0] PULSE_IDX,
  output logic             DONE,
  output logic             CFG_ERR
);

  dds_state_t       state;
  logic [CNT_W-1:0] width_q;
  logic [CNT_W-1:0] period_q;
  logic [NUM_W-1:0] num_q;
  logic [CNT_W-1:0] low_len;
  logic             cfg_ok;
  logic             idx_last;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic [CNT_W-1:0] tmr_count;
  logic             tmr_expire;

  assign low_len  = period_q - width_q;
  assign cfg_ok   = (CFG_WIDTH != '0) && (CFG_PERIOD > CFG_WIDTH) && (CFG_NUM != '0);
  assign idx_last = (PULSE_IDX == num_q - NUM_W'(1));

  // Timer is reloaded on entry to every HIGH (with WIDTH) and LOW (with PERIOD-WIDTH) phase.
  assign tmr_load  = !ABORT && ((state == ST_LOAD) ||
                                (state == ST_HIGH && tmr_expire) ||
                                (state == ST_LOW && tmr_expire && CNT_CLR));
  assign tmr_value = (state == ST_HIGH) ? low_len : width_q;

  dds_tick_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (CLK),
    .reset  (RESET),
    .load   (tmr_load),
    .value  (tmr_value),
    .count  (tmr_count),
    .expire (tmr_expire)
  );

  // CNT_CLR and the index bump are raised one cycle ahead so they appear in the last LOW cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      BUSY      <= 1'b0;
      PULSE     <= 1'b0;
      CNT_EN    <= 1'b0;
      CNT_CLR   <= 1'b0;
      PULSE_IDX <= '0;
      DONE      <= 1'b0;
      CFG_ERR   <= 1'b0;
      width_q   <= '0;
      period_q  <= '0;
      num_q     <= '0;
    end else if (ABORT) begin
      state     <= ST_IDLE;
      BUSY      <= 1'b0;
      PULSE     <= 1'b0;
      CNT_EN    <= 1'b0;
      CNT_CLR   <= 1'b0;
      PULSE_IDX <= '0;
      DONE      <= 1'b0;
      CFG_ERR   <= 1'b0;
    end else begin
      DONE    <= 1'b0;
      CFG_ERR <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START) begin
            if (cfg_ok) begin
              width_q   <= CFG_WIDTH;
              period_q  <= CFG_PERIOD;
              num_q     <= CFG_NUM;
              state     <= ST_LOAD;
              BUSY      <= 1'b1;
              CNT_CLR   <= 1'b1;
              PULSE_IDX <= '0;
            end else begin
              CFG_ERR <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          state   <= ST_HIGH;
          CNT_CLR <= 1'b0;
          PULSE   <= 1'b1;
          CNT_EN  <= 1'b1;
        end
        ST_HIGH: begin
          if (tmr_expire) begin
            state  <= ST_LOW;
            PULSE  <= 1'b0;
            CNT_EN <= 1'b0;
            if (low_len == CNT_W'(1) && !idx_last) begin
              CNT_CLR   <= 1'b1;
              PULSE_IDX <= PULSE_IDX + NUM_W'(1);
            end
          end
        end
        ST_LOW: begin
          if (tmr_expire) begin
            CNT_CLR <= 1'b0;
            if (CNT_CLR) begin
              state  <= ST_HIGH;
              PULSE  <= 1'b1;
              CNT_EN <= 1'b1;
            end else begin
              state <= ST_FIN;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
            end
          end else if (tmr_count == CNT_W'(2) && !idx_last) begin
            CNT_CLR   <= 1'b1;
            PULSE_IDX <= PULSE_IDX + NUM_W'(1);
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_burst_sequencer.sv
// Directed bench for dds_burst_sequencer: per-cycle vector table plus hand-written reset sequences.
module tb_dds_burst_sequencer;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned NUM_W = 8;

  // Expected output patterns {BUSY, PULSE, CNT_CLR, DONE, CFG_ERR}
  localparam logic [4:0] X_IDLE = 5'b00000;
  localparam logic [4:0] X_CLR  = 5'b10100;
  localparam logic [4:0] X_HIGH = 5'b11000;
  localparam logic [4:0] X_LOW  = 5'b10000;
  localparam logic [4:0] X_DONE = 5'b00010;
  localparam logic [4:0] X_ERR  = 5'b00001;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             START;
  logic             ABORT;
  logic [CNT_W-1:0] CFG_WIDTH;
  logic [CNT_W-1:0] CFG_PERIOD;
  logic [NUM_W-1:0] CFG_NUM;
  logic             BUSY;
  logic             PULSE;
  logic             CNT_EN;
  logic             CNT_CLR;
  logic [NUM_W-1:0] PULSE_IDX;
  logic             DONE;
  logic             CFG_ERR;

  dds_burst_sequencer #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .START      (START),
    .ABORT      (ABORT),
    .CFG_WIDTH  (CFG_WIDTH),
    .CFG_PERIOD (CFG_PERIOD),
    .CFG_NUM    (CFG_NUM),
    .BUSY       (BUSY),
    .PULSE      (PULSE),
    .CNT_EN     (CNT_EN),
    .CNT_CLR    (CNT_CLR),
    .PULSE_IDX  (PULSE_IDX),
    .DONE       (DONE),
    .CFG_ERR    (CFG_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      tag;
    logic       start;
    logic       abort;
    int         w;
    int         p;
    int         n;
    logic [4:0] exp;
    int         idx;   // -1: index not checked this cycle
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic v(input string tag, input logic s, input logic a, input int w, input int p,
                   input int n, input logic [4:0] e, input int idx);
    vec_t r;
    r.tag = tag; r.start = s; r.abort = a; r.w = w; r.p = p; r.n = n; r.exp = e; r.idx = idx;
    vecs.push_back(r);
  endtask

  // W=3,P=5,N=2 started in cycle 0: clr 1,6; pulse 2-4,7-9; done 12; busy 1-11
  task automatic add_basic(input string tag);
    v(tag, 1, 0, 3, 5, 2, X_IDLE, -1);
    v(tag, 0, 0, 3, 5, 2, X_CLR,   0);
    for (int k = 0; k < 3; k++) v(tag, 0, 0, 3, 5, 2, X_HIGH, 0);
    v(tag, 0, 0, 3, 5, 2, X_LOW,   0);
    v(tag, 0, 0, 3, 5, 2, X_CLR,  -1);
    for (int k = 0; k < 3; k++) v(tag, 0, 0, 3, 5, 2, X_HIGH, 1);
    v(tag, 0, 0, 3, 5, 2, X_LOW,   1);
    v(tag, 0, 0, 3, 5, 2, X_LOW,   1);
    v(tag, 0, 0, 3, 5, 2, X_DONE, -1);
    v(tag, 0, 0, 3, 5, 2, X_IDLE, -1);
  endtask

  task automatic add_bad(input string tag, input int w, input int p, input int n);
    v(tag, 1, 0, w, p, n, X_IDLE, -1);
    v(tag, 0, 0, w, p, n, X_ERR,  -1);
    v(tag, 0, 0, w, p, n, X_IDLE, -1);
  endtask

  initial begin
    int   done_at;
    int   rise1;
    int   rise2;
    int   clr_at;
    int   pulse_cnt;
    logic prev_pulse;

    RESET = 1'b1; START = 1'b0; ABORT = 1'b0;
    CFG_WIDTH = '0; CFG_PERIOD = '0; CFG_NUM = '0;

    add_basic("basic");
    // minimum legal burst
    v("min", 1, 0, 1, 2, 1, X_IDLE, -1);
    v("min", 0, 0, 1, 2, 1, X_CLR,   0);
    v("min", 0, 0, 1, 2, 1, X_HIGH,  0);
    v("min", 0, 0, 1, 2, 1, X_LOW,   0);
    v("min", 0, 0, 1, 2, 1, X_DONE, -1);
    v("min", 0, 0, 1, 2, 1, X_IDLE, -1);
    add_bad("bad_w0",  0, 5, 2);
    add_bad("bad_peqw", 4, 4, 2);
    add_bad("bad_n0",  3, 5, 0);
    add_bad("bad_pltw", 5, 3, 1);
    // abort during the second pulse of a 4-pulse burst
    v("abort", 1, 0, 3, 5, 4, X_IDLE, -1);
    v("abort", 0, 0, 3, 5, 4, X_CLR,   0);
    for (int k = 0; k < 3; k++) v("abort", 0, 0, 3, 5, 4, X_HIGH, 0);
    v("abort", 0, 0, 3, 5, 4, X_LOW,   0);
    v("abort", 0, 0, 3, 5, 4, X_CLR,  -1);
    v("abort", 0, 0, 3, 5, 4, X_HIGH,  1);
    v("abort", 0, 1, 3, 5, 4, X_HIGH,  1);
    for (int k = 0; k < 16; k++) v("abort_idle", 0, 0, 3, 5, 4, X_IDLE, 0);
    add_basic("after_abort");
    // START re-pulsed mid-burst with other configs, START in FIN, START+ABORT in IDLE
    v("repulse", 1, 0, 3, 5, 2, X_IDLE, -1);
    v("repulse", 0, 0, 3, 5, 2, X_CLR,   0);
    v("repulse", 0, 0, 3, 5, 2, X_HIGH,  0);
    v("repulse", 1, 0, 1, 2, 1, X_HIGH,  0);
    v("repulse", 0, 0, 1, 2, 1, X_HIGH,  0);
    v("repulse", 1, 0, 7, 9, 3, X_LOW,   0);
    v("repulse", 0, 0, 7, 9, 3, X_CLR,  -1);
    v("repulse", 1, 0, 4, 9, 3, X_HIGH,  1);
    v("repulse", 0, 0, 4, 9, 3, X_HIGH,  1);
    v("repulse", 0, 0, 4, 9, 3, X_HIGH,  1);
    v("repulse", 0, 0, 4, 9, 3, X_LOW,   1);
    v("repulse", 0, 0, 4, 9, 3, X_LOW,   1);
    v("repulse", 1, 0, 1, 2, 1, X_DONE, -1);
    v("start_abort", 1, 1, 1, 2, 1, X_IDLE, -1);
    v("start_abort", 1, 1, 0, 5, 2, X_IDLE, 0);
    v("start_abort", 0, 0, 0, 5, 2, X_IDLE, 0);
    v("start_abort", 0, 0, 0, 5, 2, X_IDLE, 0);

    // reset state
    #23;
    chk("reset_busy", 32'(BUSY), 0);
    chk("reset_pulse", 32'(PULSE), 0);
    chk("reset_cnt_en", 32'(CNT_EN), 0);
    chk("reset_cnt_clr", 32'(CNT_CLR), 0);
    chk("reset_idx", 32'(PULSE_IDX), 0);
    chk("reset_done", 32'(DONE), 0);
    chk("reset_cfg_err", 32'(CFG_ERR), 0);
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge CLK); #1;
      chk($sformatf("%s[%0d].busy", vecs[i].tag, i), 32'(BUSY), 32'(vecs[i].exp[4]));
      chk($sformatf("%s[%0d].pulse", vecs[i].tag, i), 32'(PULSE), 32'(vecs[i].exp[3]));
      chk($sformatf("%s[%0d].cnt_en", vecs[i].tag, i), 32'(CNT_EN), 32'(vecs[i].exp[3]));
      chk($sformatf("%s[%0d].cnt_clr", vecs[i].tag, i), 32'(CNT_CLR), 32'(vecs[i].exp[2]));
      chk($sformatf("%s[%0d].done", vecs[i].tag, i), 32'(DONE), 32'(vecs[i].exp[1]));
      chk($sformatf("%s[%0d].cfg_err", vecs[i].tag, i), 32'(CFG_ERR), 32'(vecs[i].exp[0]));
      if (vecs[i].idx >= 0)
        chk($sformatf("%s[%0d].idx", vecs[i].tag, i), 32'(PULSE_IDX), 32'(vecs[i].idx));
      START      = vecs[i].start;
      ABORT      = vecs[i].abort;
      CFG_WIDTH  = CNT_W'(vecs[i].w);
      CFG_PERIOD = CNT_W'(vecs[i].p);
      CFG_NUM    = NUM_W'(vecs[i].n);
    end
    @(posedge CLK); #1;
    START = 1'b0; ABORT = 1'b0;

    // asynchronous reset in the middle of a HIGH phase
    @(posedge CLK); #1;
    START = 1'b1; CFG_WIDTH = 16'd3; CFG_PERIOD = 16'd5; CFG_NUM = 8'd2;
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK); #1;
    chk("pre_reset_pulse", 32'(PULSE), 1);
    #3;
    RESET = 1'b1;
    #1;
    chk("async_rst_pulse", 32'(PULSE), 0);
    chk("async_rst_busy", 32'(BUSY), 0);
    chk("async_rst_cnt_en", 32'(CNT_EN), 0);
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    chk("rst_held_busy", 32'(BUSY), 0);

    // fresh burst after release, timed with a bounded watch loop
    START = 1'b1;
    done_at = -1; rise1 = -1; rise2 = -1; clr_at = -1; pulse_cnt = 0; prev_pulse = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge CLK); #1;
      if (c == 1) START = 1'b0;
      if (CNT_CLR && clr_at < 0) clr_at = c;
      if (PULSE) pulse_cnt++;
      if (PULSE && !prev_pulse) begin
        if (rise1 < 0) rise1 = c;
        else if (rise2 < 0) rise2 = c;
      end
      prev_pulse = PULSE;
      if (DONE) begin
        done_at = c;
        break;
      end
    end
    chk("post_rst_first_clr", 32'(clr_at), 1);
    chk("post_rst_rise1", 32'(rise1), 2);
    chk("post_rst_rise2", 32'(rise2), 7);
    chk("post_rst_pulse_cycles", 32'(pulse_cnt), 6);
    chk("post_rst_done_cycle", 32'(done_at), 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
